ia_frame_ctrl: RTL and testbench

IA_FRAME_CTRL -- requirements
Module: ia_frame_ctrl

---
 rtl/ia_frame_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_ia_frame_ctrl.sv | 461 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ia_frame_ctrl.sv
//-----------------------------------------------------------------------------
// ia_frame_ctrl
//
// Receive-side frame controller for the triangle-parameter UART link.
// A frame is the sync marker SYNC_BYTE followed by NUM_BYTES payload bytes
// (27 16-bit words, low byte first). Each payload byte is forwarded one cycle
// after it arrives as a registered write (byte_out/idx/update_reg) into the
// parameter register file. Once the whole payload is in, the controller waits
// for the next vblank pulse (frame_start) and only then announces the new
// triangle with a one-cycle pc_ready, so the renderer never switches
// parameters mid-frame.
//
// A gap of TIMEOUT idle clocks inside a frame abandons it (err_timeout).
// Bytes already written are not rolled back; withholding pc_ready is what
// keeps a partial frame from being used.
//
// Optional feature, enabled by defining the macro IA_CHECKSUM_EN:
//   one extra byte follows the payload and must equal the XOR of all payload
//   bytes. A mismatch pulses err_cksum and discards the frame. Without the
//   macro the checksum state, accumulator and error register are not built
//   and err_cksum is tied low.
//-----------------------------------------------------------------------------
module ia_frame_ctrl #(
   parameter logic [7:0] SYNC_BYTE = 8'hA5,
   parameter int         NUM_BYTES = 54,
   parameter int         TIMEOUT   = 1_000_000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] rx_data,
   input  logic       rx_done,
   input  logic       frame_start,
   output logic [7:0] byte_out,
   output logic [5:0] idx,
   output logic       update_reg,
   output logic       pc_ready,
   output logic       busy,
   output logic       err_timeout,
   output logic       err_cksum
);

   // Idle counter is sized to hold TIMEOUT itself so the compare value fits.
   localparam int                IDLE_W    = $clog2(TIMEOUT + 1);
   localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT - 1);
   localparam logic [IDLE_W-1:0] IDLE_MAX  = '1;
   localparam logic [5:0]        BYTE_LAST = 6'(NUM_BYTES - 1);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_LOAD   = 2'd1,
      ST_CHECK  = 2'd2,
      ST_COMMIT = 2'd3
   } state_t;

   state_t            state;
   logic [5:0]        byte_cnt;
   logic [IDLE_W-1:0] idle_cnt;

   // True on the cycle the in-frame silence reaches TIMEOUT clocks.
   logic idle_expired;
   assign idle_expired = (idle_cnt == IDLE_LAST) && !rx_done;

`ifdef IA_CHECKSUM_EN
   logic [7:0] cksum_acc;
`else
   assign err_cksum = 1'b0;
`endif

   // Frame FSM: hunt for sync, stream payload writes, optionally verify the
   // checksum, then hold the completed frame until the next vblank.
   // NOTE: every register here is assigned with <= so all of them update from
   // the same pre-edge values; blocking assignments would make the result
   // depend on statement order.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= ST_IDLE;
         byte_cnt    <= '0;
         idle_cnt    <= '0;
         byte_out    <= '0;
         idx         <= '0;
         update_reg  <= 1'b0;
         pc_ready    <= 1'b0;
         busy        <= 1'b0;
         err_timeout <= 1'b0;
`ifdef IA_CHECKSUM_EN
         cksum_acc   <= '0;
         err_cksum   <= 1'b0;
`endif
      end else begin
         // NOTE: strobes fall back to 0 every cycle and are raised only by the
         // branch that fires them, which makes each pulse exactly one clock.
         update_reg  <= 1'b0;
         pc_ready    <= 1'b0;
         err_timeout <= 1'b0;
`ifdef IA_CHECKSUM_EN
         err_cksum   <= 1'b0;
`endif

         case (state)
            // Non-sync bytes are noise between frames and are ignored.
            ST_IDLE: begin
               if (rx_done && (rx_data == SYNC_BYTE)) begin
                  state    <= ST_LOAD;
                  busy     <= 1'b1;
                  byte_cnt <= '0;
                  idle_cnt <= '0;
`ifdef IA_CHECKSUM_EN
                  cksum_acc <= '0;
`endif
               end
            end

            // Each byte becomes one register-file write on the next cycle.
            ST_LOAD: begin
               if (rx_done) begin
                  byte_out   <= rx_data;
                  idx        <= byte_cnt;
                  update_reg <= 1'b1;
                  idle_cnt   <= '0;
`ifdef IA_CHECKSUM_EN
                  cksum_acc  <= cksum_acc ^ rx_data;
`endif
                  if (byte_cnt == BYTE_LAST) begin
                     byte_cnt <= '0;
`ifdef IA_CHECKSUM_EN
                     state    <= ST_CHECK;
`else
                     state    <= ST_COMMIT;
`endif
                  end else begin
                     byte_cnt <= byte_cnt + 1'b1;
                  end
               end else if (idle_expired) begin
                  err_timeout <= 1'b1;
                  state       <= ST_IDLE;
                  busy        <= 1'b0;
                  idle_cnt    <= '0;
                  byte_cnt    <= '0;
               end else if (idle_cnt != IDLE_MAX) begin
                  idle_cnt <= idle_cnt + 1'b1;
               end
            end

`ifdef IA_CHECKSUM_EN
            // The checksum byte is compared only; it never reaches the
            // register file.
            ST_CHECK: begin
               if (rx_done) begin
                  idle_cnt <= '0;
                  if (rx_data == cksum_acc) begin
                     state <= ST_COMMIT;
                  end else begin
                     err_cksum <= 1'b1;
                     state     <= ST_IDLE;
                     busy      <= 1'b0;
                  end
               end else if (idle_expired) begin
                  err_timeout <= 1'b1;
                  state       <= ST_IDLE;
                  busy        <= 1'b0;
                  idle_cnt    <= '0;
               end else if (idle_cnt != IDLE_MAX) begin
                  idle_cnt <= idle_cnt + 1'b1;
               end
            end
`endif

            // Bytes arriving here are dropped (even a sync byte); the frame is
            // released on the first vblank seen while already in this state,
            // so a pulse coinciding with the final byte is not used.
            ST_COMMIT: begin
               if (frame_start) begin
                  pc_ready <= 1'b1;
                  state    <= ST_IDLE;
                  busy     <= 1'b0;
               end
            end

            default: begin
               state <= ST_IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ia_frame_ctrl.sv
//-----------------------------------------------------------------------------
// tb_ia_frame_ctrl
//
// Self-checking bench for ia_frame_ctrl. Stimulus is a byte stream with
// random payloads and random inter-byte gaps. A stream-level reference model
// decides, byte by byte, which bytes must appear as register writes and how
// many pc_ready / err_cksum pulses are owed. A negedge monitor records what
// the DUT actually produced. Works with or without IA_CHECKSUM_EN.
//-----------------------------------------------------------------------------
module tb_ia_frame_ctrl;

   localparam logic [7:0] SYNC = 8'hA5;
   localparam int         NB   = 54;
   localparam int         TO   = 100;
`ifdef IA_CHECKSUM_EN
   localparam bit CK = 1'b1;
`else
   localparam bit CK = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic [7:0] rx_data = 8'h00;
   logic       rx_done = 1'b0;
   logic       frame_start = 1'b0;
   logic [7:0] byte_out;
   logic [5:0] idx;
   logic       update_reg, pc_ready, busy, err_timeout, err_cksum;

   always #5 clk = ~clk;

   ia_frame_ctrl #(.SYNC_BYTE(SYNC), .NUM_BYTES(NB), .TIMEOUT(TO)) dut (
      .clk(clk), .reset(reset), .rx_data(rx_data), .rx_done(rx_done),
      .frame_start(frame_start), .byte_out(byte_out), .idx(idx),
      .update_reg(update_reg), .pc_ready(pc_ready), .busy(busy),
      .err_timeout(err_timeout), .err_cksum(err_cksum)
   );

   int checks = 0;
   int errors = 0;

   // ---------------- monitor ----------------
   logic [13:0] got_q[$];
   logic [13:0] exp_q[$];
   int   cyc = 0, pc_cnt = 0, to_cnt = 0, ck_cnt = 0;
   int   overlap = 0, lat_bad = 0, pc_lat_bad = 0;
   int   last_rx_cyc = 0, to_cyc = 0;
   logic prev_rx = 1'b0, prev_fs = 1'b0;

   always @(negedge clk) begin
      cyc++;
      if (update_reg) begin
         got_q.push_back({idx, byte_out});
         if (!prev_rx) lat_bad++;
      end
      if (update_reg && pc_ready) overlap++;
      if (pc_ready) begin
         pc_cnt++;
         if (!prev_fs) pc_lat_bad++;
      end
      if (err_timeout) begin
         to_cnt++;
         to_cyc = cyc;
      end
      if (err_cksum) ck_cnt++;
      if (rx_done) last_rx_cyc = cyc;
      prev_rx = rx_done;
      prev_fs = frame_start;
   end

   // ---------------- reference model (stream level) ----------------
   typedef enum {P_HUNT, P_PAYLOAD, P_CKSUM, P_WAIT_VBLANK} phase_t;
   phase_t     m_phase = P_HUNT;
   int         m_cnt = 0;
   logic [7:0] m_xor = 8'h00;
   int         exp_pc = 0, exp_ck = 0, exp_to = 0;

   task automatic model_byte(input logic [7:0] b);
      case (m_phase)
         P_HUNT: if (b == SYNC) begin
            m_phase = P_PAYLOAD;
            m_cnt   = 0;
            m_xor   = 8'h00;
         end
         P_PAYLOAD: begin
            exp_q.push_back({6'(m_cnt), b});
            m_xor = m_xor ^ b;
            m_cnt++;
            if (m_cnt == NB) begin
               if (CK) m_phase = P_CKSUM;
               else    m_phase = P_WAIT_VBLANK;
            end
         end
         P_CKSUM: begin
            if (b == m_xor) m_phase = P_WAIT_VBLANK;
            else begin
               exp_ck++;
               m_phase = P_HUNT;
            end
         end
         default: ;  // waiting for vblank: byte dropped
      endcase
   endtask

   task automatic model_fs();
      if (m_phase == P_WAIT_VBLANK) begin
         exp_pc++;
         m_phase = P_HUNT;
      end
   endtask

   // ---------------- drivers ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // fs_same raises frame_start in the same cycle as this byte.
   task automatic send_byte(input logic [7:0] b, input bit fs_same = 1'b0);
      if (fs_same) begin
         frame_start = 1'b1;
         model_fs();
      end
      rx_data = b;
      rx_done = 1'b1;
      model_byte(b);
      tick();
      rx_done     = 1'b0;
      frame_start = 1'b0;
      repeat ($urandom_range(0, 3)) tick();
   endtask

   task automatic pulse_fs();
      frame_start = 1'b1;
      model_fs();
      tick();
      frame_start = 1'b0;
      repeat (3) tick();
   endtask

   task automatic send_frame(input logic [7:0] pl[$], input bit good_ck, input bit fs_on_last);
      send_byte(SYNC);
      for (int i = 0; i < pl.size(); i++)
         send_byte(pl[i], fs_on_last && !CK && (i == pl.size() - 1));
      if (CK) send_byte(good_ck ? m_xor : 8'h00, fs_on_last);
   endtask

   function automatic int write_diff();
      if (got_q.size() != exp_q.size())
         return (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
      foreach (exp_q[i]) if (got_q[i] !== exp_q[i]) return i;
      return -1;
   endfunction

   // ---------------- tests ----------------
   task automatic test_reset();
      #2 reset = 1'b1;
      #10;
      checks++;
      if ({byte_out, idx, update_reg, pc_ready, busy, err_timeout, err_cksum} !== 19'd0) begin
         errors++;
         $display("FAIL reset_outputs got=%h want=0",
                  {byte_out, idx, update_reg, pc_ready, busy, err_timeout, err_cksum});
      end
      @(posedge clk);
      #1 reset = 1'b0;
      m_phase = P_HUNT;
      repeat (3) tick();
      checks++;
      if ({update_reg, pc_ready, busy, err_timeout, err_cksum} !== 5'd0) begin
         errors++;
         $display("FAIL idle_after_reset got=%b want=00000",
                  {update_reg, pc_ready, busy, err_timeout, err_cksum});
      end
   endtask

   task automatic test_good_frame();
      logic [7:0] pl[$];
      int pc0 = pc_cnt, epc0 = exp_pc, d;
      got_q.delete();
      exp_q.delete();
      for (int i = 0; i < NB; i++) pl.push_back(8'(i));
      send_frame(pl, 1'b1, 1'b0);
      repeat (2) tick();
      checks++;
      if (busy !== 1'b1) begin
         errors++;
         $display("FAIL good_busy_awaiting_vblank got=%b want=1", busy);
      end
      checks++;
      if (pc_cnt - pc0 !== 0) begin
         errors++;
         $display("FAIL good_early_pc_ready got=%0d want=0", pc_cnt - pc0);
      end
      pulse_fs();
      d = write_diff();
      checks++;
      if (d != -1) begin
         errors++;
         $display("FAIL good_writes first_diff=%0d got_n=%0d want_n=%0d", d, got_q.size(), exp_q.size());
      end
      checks++;
      if (pc_cnt - pc0 !== exp_pc - epc0 || exp_pc - epc0 != 1) begin
         errors++;
         $display("FAIL good_pc_ready got=%0d want=1", pc_cnt - pc0);
      end
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL good_busy_after_commit got=%b want=0", busy);
      end
   endtask

   task automatic test_noise_then_frame();
      logic [7:0] pl[$];
      int pc0 = pc_cnt, epc0 = exp_pc, d;
      got_q.delete();
      exp_q.delete();
      send_byte(8'h11);
      send_byte(8'h22);
      for (int i = 0; i < 4; i++) begin
         logic [7:0] n = 8'($urandom());
         if (n == SYNC) n = 8'h5A;
         send_byte(n);
      end
      checks++;
      if (got_q.size() != 0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL noise_ignored got_writes=%0d busy=%b want 0/0", got_q.size(), busy);
      end
      for (int i = 0; i < NB; i++) pl.push_back(8'($urandom()));
      send_frame(pl, 1'b1, 1'b0);
      pulse_fs();
      d = write_diff();
      checks++;
      if (d != -1) begin
         errors++;
         $display("FAIL noise_writes first_diff=%0d got_n=%0d want_n=%0d", d, got_q.size(), exp_q.size());
      end
      checks++;
      if (pc_cnt - pc0 !== exp_pc - epc0) begin
         errors++;
         $display("FAIL noise_pc_ready got=%0d want=%0d", pc_cnt - pc0, exp_pc - epc0);
      end
   endtask

   task automatic test_timeout();
      int to0 = to_cnt, pc0 = pc_cnt, waited = 0, d;
      got_q.delete();
      exp_q.delete();
      send_byte(SYNC);
      for (int i = 0; i < 10; i++) send_byte(8'($urandom()));
      while (to_cnt == to0 && waited < 3 * TO) begin
         tick();
         waited++;
      end
      exp_to++;
      m_phase = P_HUNT;
      checks++;
      if (to_cnt - to0 !== 1) begin
         errors++;
         $display("FAIL timeout_seen got=%0d want=1", to_cnt - to0);
      end
      // TO silent cycles follow the last byte; the pulse is in the next one.
      checks++;
      if (to_cyc - last_rx_cyc !== TO + 1) begin
         errors++;
         $display("FAIL timeout_latency got=%0d want=%0d", to_cyc - last_rx_cyc, TO + 1);
      end
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL timeout_busy got=%b want=0", busy);
      end
      d = write_diff();
      checks++;
      if (d != -1 || got_q.size() != 10) begin
         errors++;
         $display("FAIL timeout_partial_writes first_diff=%0d got_n=%0d want_n=10", d, got_q.size());
      end
      // No further timeout while idle, and no commit on a later vblank.
      repeat (2 * TO) tick();
      pulse_fs();
      checks++;
      if (to_cnt - to0 !== 1 || pc_cnt - pc0 !== 0) begin
         errors++;
         $display("FAIL timeout_aftermath got_to=%0d got_pc=%0d want 1/0", to_cnt - to0, pc_cnt - pc0);
      end
   endtask

   task automatic test_reset_mid_frame();
      logic [7:0] pl[$];
      int pc0, epc0, d;
      got_q.delete();
      exp_q.delete();
      send_byte(SYNC);
      for (int i = 0; i < 20; i++) send_byte(8'($urandom()));
      checks++;
      if (busy !== 1'b1) begin
         errors++;
         $display("FAIL midframe_busy got=%b want=1", busy);
      end
      #2 reset = 1'b1;
      #1;
      checks++;
      if ({byte_out, idx, update_reg, pc_ready, busy, err_timeout, err_cksum} !== 19'd0) begin
         errors++;
         $display("FAIL midframe_reset_outputs got=%h want=0",
                  {byte_out, idx, update_reg, pc_ready, busy, err_timeout, err_cksum});
      end
      d = write_diff();
      checks++;
      if (d != -1) begin
         errors++;
         $display("FAIL midframe_writes first_diff=%0d got_n=%0d want_n=%0d", d, got_q.size(), exp_q.size());
      end
      @(posedge clk);
      #1 reset = 1'b0;
      m_phase = P_HUNT;
      tick();
      got_q.delete();
      exp_q.delete();
      pc0  = pc_cnt;
      epc0 = exp_pc;
      send_byte(8'h3C);  // would be payload if the old frame survived
      for (int i = 0; i < NB; i++) pl.push_back(8'($urandom()));
      send_frame(pl, 1'b1, 1'b0);
      pulse_fs();
      d = write_diff();
      checks++;
      if (d != -1) begin
         errors++;
         $display("FAIL post_reset_writes first_diff=%0d got_n=%0d want_n=%0d", d, got_q.size(), exp_q.size());
      end
      checks++;
      if (pc_cnt - pc0 !== exp_pc - epc0 || exp_pc - epc0 != 1) begin
         errors++;
         $display("FAIL post_reset_pc_ready got=%0d want=1", pc_cnt - pc0);
      end
   endtask

   task automatic test_commit_drop();
      logic [7:0] pl[$];
      int pc0 = pc_cnt, epc0 = exp_pc, to0 = to_cnt, d;
      got_q.delete();
      exp_q.delete();
      for (int i = 0; i < NB; i++) pl.push_back(8'($urandom()));
      send_frame(pl, 1'b1, 1'b1);  // vblank coincides with the final byte
      repeat (2 * TO) tick();
      send_byte(SYNC);
      for (int i = 0; i < 5; i++) send_byte(8'($urandom()));
      checks++;
      if (pc_cnt - pc0 !== 0 || to_cnt - to0 !== 0) begin
         errors++;
         $display("FAIL commit_hold got_pc=%0d got_to=%0d want 0/0", pc_cnt - pc0, to_cnt - to0);
      end
      pulse_fs();
      d = write_diff();
      checks++;
      if (d != -1 || got_q.size() != NB) begin
         errors++;
         $display("FAIL commit_drop_writes first_diff=%0d got_n=%0d want_n=%0d", d, got_q.size(), NB);
      end
      checks++;
      if (pc_cnt - pc0 !== exp_pc - epc0 || exp_pc - epc0 != 1) begin
         errors++;
         $display("FAIL commit_drop_pc_ready got=%0d want=1", pc_cnt - pc0);
      end
   endtask

`ifdef IA_CHECKSUM_EN
   task automatic test_bad_cksum();
      logic [7:0] pl[$];
      int pc0 = pc_cnt, ck0 = ck_cnt, d;
      got_q.delete();
      exp_q.delete();
      for (int i = 0; i < NB; i++) pl.push_back(8'(i));
      send_frame(pl, 1'b0, 1'b0);
      tick();
      checks++;
      if (ck_cnt - ck0 !== 1 || busy !== 1'b0) begin
         errors++;
         $display("FAIL bad_cksum got_err=%0d busy=%b want 1/0", ck_cnt - ck0, busy);
      end
      pulse_fs();
      d = write_diff();
      checks++;
      if (d != -1 || pc_cnt - pc0 !== 0) begin
         errors++;
         $display("FAIL bad_cksum_discard first_diff=%0d got_pc=%0d want -1/0", d, pc_cnt - pc0);
      end
   endtask
`endif

   task automatic test_back_to_back();
      int pc0 = pc_cnt, epc0 = exp_pc, d;
      got_q.delete();
      exp_q.delete();
      for (int f = 0; f < 3; f++) begin
         logic [7:0] pl[$];
         repeat ($urandom_range(0, 3)) send_byte(8'($urandom()));
         for (int i = 0; i < NB; i++) pl.push_back(8'($urandom()));
         send_frame(pl, 1'b1, 1'b0);
         pulse_fs();
      end
      d = write_diff();
      checks++;
      if (d != -1) begin
         errors++;
         $display("FAIL b2b_writes first_diff=%0d got_n=%0d want_n=%0d", d, got_q.size(), exp_q.size());
      end
      checks++;
      if (pc_cnt - pc0 !== exp_pc - epc0) begin
         errors++;
         $display("FAIL b2b_pc_ready got=%0d want=%0d", pc_cnt - pc0, exp_pc - epc0);
      end
   endtask

   task automatic test_invariants();
      checks++;
      if (overlap !== 0) begin
         errors++;
         $display("FAIL update_pc_overlap got=%0d want=0", overlap);
      end
      checks++;
      if (lat_bad !== 0 || pc_lat_bad !== 0) begin
         errors++;
         $display("FAIL pulse_latency got_wr=%0d got_pc=%0d want 0/0", lat_bad, pc_lat_bad);
      end
      checks++;
      if (ck_cnt !== exp_ck || to_cnt !== exp_to || pc_cnt !== exp_pc) begin
         errors++;
         $display("FAIL event_totals got ck=%0d to=%0d pc=%0d want ck=%0d to=%0d pc=%0d",
                  ck_cnt, to_cnt, pc_cnt, exp_ck, exp_to, exp_pc);
      end
   endtask

   initial begin
      test_reset();
      test_good_frame();
      test_noise_then_frame();
      test_timeout();
      test_reset_mid_frame();
      test_commit_drop();
`ifdef IA_CHECKSUM_EN
      test_bad_cksum();
`endif
      test_back_to_back();
      test_invariants();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   // Absolute time bound so the run always ends.
   initial begin
      #2_000_000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1);
   end

endmodule
